// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED geometry, coordinate widths, direction and sprite-mover state types
package oled_pkg;

    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int SPRITE_W = 8;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        SPLASH   = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

endpackage

// File: rtl/waterball_motion_if.sv
// rtl/waterball_motion_if.sv - water-ball launch/position bundle; splash present under WATERBALL_SPLASH_EN
interface waterball_motion_if;
    import oled_pkg::*;

    logic           fire;
    logic           dir;
    logic [X_W-1:0] spawn_x;
    logic [Y_W-1:0] spawn_y;
    logic           hit;
    logic [X_W-1:0] left_x;
    logic [Y_W-1:0] top_y;
    logic           active;
    logic           busy;
`ifdef WATERBALL_SPLASH_EN
    logic           splash;

    modport master (
        output fire, dir, spawn_x, spawn_y, hit,
        input  left_x, top_y, active, busy, splash
    );

    modport slave (
        input  fire, dir, spawn_x, spawn_y, hit,
        output left_x, top_y, active, busy, splash
    );
`else
    modport master (
        output fire, dir, spawn_x, spawn_y, hit,
        input  left_x, top_y, active, busy
    );

    modport slave (
        input  fire, dir, spawn_x, spawn_y, hit,
        output left_x, top_y, active, busy
    );
`endif

endinterface

// File: rtl/waterball_motion_tick_gen.sv
// rtl/waterball_motion_tick_gen.sv - divide-by-DIV movement tick with synchronous clear
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int           CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Free-running 0..DIV-1 counter; clr realigns it so a move lands exactly DIV cycles later
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/waterball_motion.sv
// rtl/waterball_motion.sv - water-ball projectile FSM and position datapath; optional SPLASH via WATERBALL_SPLASH_EN
module waterball_motion
    import oled_pkg::*;
#(
    parameter int STEP_DIV       = 6250000,
    parameter int SPEED          = 2,
    parameter int SCREEN_W       = oled_pkg::SCREEN_W,
    parameter int SCREEN_H       = oled_pkg::SCREEN_H,
    parameter int SPRITE_W       = oled_pkg::SPRITE_W,
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    waterball_motion_if.slave  bus
);

    localparam logic [7:0] X_MAX   = 8'(SCREEN_W - SPRITE_W);
    localparam logic [7:0] Y_MAX   = 8'(SCREEN_H - SPRITE_W);
    localparam logic [7:0] SPD     = 8'(SPEED);
    localparam logic [7:0] CD_LAST = 8'(COOLDOWN_TICKS - 1);
    localparam state_e     RET_ST  = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;

    state_e         state, state_n;
    dir_e           dir_q, dir_n;
    logic [X_W-1:0] left_x, x_n;
    logic [Y_W-1:0] top_y, y_n;
    logic           active, act_n;
    logic           busy, busy_n;
    logic [7:0]     tcnt, tcnt_n;
    logic           clr;
    logic           tick;
    logic [7:0]     x_up;
`ifdef WATERBALL_SPLASH_EN
    logic           splash_q, spl_n;
    assign bus.splash = splash_q;
`endif

    assign bus.left_x = left_x;
    assign bus.top_y  = top_y;
    assign bus.active = active;
    assign bus.busy   = busy;

    // Rightward candidate in 8 bits so the edge test cannot wrap
    assign x_up = {1'b0, left_x} + SPD;

    tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Next state and next datapath values; hit beats edge, edge beats move
    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        x_n     = left_x;
        y_n     = top_y;
        act_n   = active;
        busy_n  = busy;
        tcnt_n  = tcnt;
        clr     = 1'b0;
`ifdef WATERBALL_SPLASH_EN
        spl_n   = splash_q;
`endif
        case (state)
            IDLE: begin
                if (bus.fire) begin
                    state_n = FLY;
                    x_n     = ({1'b0, bus.spawn_x} > X_MAX) ? X_MAX[X_W-1:0] : bus.spawn_x;
                    y_n     = ({2'b00, bus.spawn_y} > Y_MAX) ? Y_MAX[Y_W-1:0] : bus.spawn_y;
                    dir_n   = dir_e'(bus.dir);
                    act_n   = 1'b1;
                    busy_n  = 1'b1;
                    tcnt_n  = '0;
                    clr     = 1'b1;
                end
            end
            FLY: begin
                if (bus.hit) begin
                    tcnt_n = '0;
`ifdef WATERBALL_SPLASH_EN
                    state_n = SPLASH;
                    spl_n   = 1'b1;
`else
                    state_n = RET_ST;
                    act_n   = 1'b0;
                    busy_n  = (RET_ST != IDLE);
`endif
                end else if (tick) begin
                    if ((dir_q == DIR_RIGHT && x_up > X_MAX) ||
                        (dir_q == DIR_LEFT && {1'b0, left_x} < SPD)) begin
                        state_n = RET_ST;
                        act_n   = 1'b0;
                        busy_n  = (RET_ST != IDLE);
                        tcnt_n  = '0;
                    end else if (dir_q == DIR_RIGHT) begin
                        x_n = x_up[X_W-1:0];
                    end else begin
                        x_n = left_x - SPD[X_W-1:0];
                    end
                end
            end
`ifdef WATERBALL_SPLASH_EN
            SPLASH: begin
                if (tick) begin
                    if (tcnt == 8'd1) begin
                        state_n = RET_ST;
                        act_n   = 1'b0;
                        spl_n   = 1'b0;
                        busy_n  = (RET_ST != IDLE);
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt + 8'd1;
                    end
                end
            end
`endif
            COOLDOWN: begin
                if (tick) begin
                    if (tcnt == CD_LAST) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                act_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any flight immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            dir_q  <= DIR_RIGHT;
            left_x <= '0;
            top_y  <= '0;
            active <= 1'b0;
            busy   <= 1'b0;
            tcnt   <= '0;
`ifdef WATERBALL_SPLASH_EN
            splash_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            dir_q  <= dir_n;
            left_x <= x_n;
            top_y  <= y_n;
            active <= act_n;
            busy   <= busy_n;
            tcnt   <= tcnt_n;
`ifdef WATERBALL_SPLASH_EN
            splash_q <= spl_n;
`endif
        end
    end

endmodule

// File: tb/tb_waterball_motion.sv
// tb/tb_waterball_motion.sv - scoreboard bench for waterball_motion (STEP_DIV=4, SPEED=2, COOLDOWN_TICKS=3)
module tb_waterball_motion;
    import oled_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;

    waterball_motion_if bus ();

    waterball_motion #(
        .STEP_DIV       (4),
        .SPEED          (2),
        .COOLDOWN_TICKS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bench cycle index: value after the Nth rising edge is N
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [6:0] x;
        logic [5:0] y;
        logic       act;
        logic       bsy;
        logic       spl;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   nvec  = 0;
    int   nfail = 0;

`ifdef WATERBALL_SPLASH_EN
    localparam int E_IDLE = 262;
`else
    localparam int E_IDLE = 254;
`endif
    localparam int T = E_IDLE;

    task automatic push_exp(input int at, input string name, input logic [6:0] x,
                            input logic [5:0] y, input logic act, input logic bsy,
                            input logic spl);
        exp_t e;
        e.at = at; e.name = name; e.x = x; e.y = y;
        e.act = act; e.bsy = bsy; e.spl = spl;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop every expectation due this cycle and compare against the DUT
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            m_e = sb.pop_front();
            nvec++;
            if (m_e.at != cyc) begin
                nfail++;
                $display("FAIL %s: checked at cycle %0d, required at cycle %0d", m_e.name, cyc, m_e.at);
            end else if (bus.left_x !== m_e.x || bus.top_y !== m_e.y ||
                         bus.active !== m_e.act || bus.busy !== m_e.bsy
`ifdef WATERBALL_SPLASH_EN
                         || bus.splash !== m_e.spl
`endif
                         ) begin
                nfail++;
                $display("FAIL %s @%0d: got x=%0d y=%0d act=%b busy=%b, want x=%0d y=%0d act=%b busy=%b spl=%b",
                         m_e.name, cyc, bus.left_x, bus.top_y, bus.active, bus.busy,
                         m_e.x, m_e.y, m_e.act, m_e.bsy, m_e.spl);
            end
        end
    end

    initial begin
        bus.fire = 1'b0; bus.dir = 1'b0; bus.spawn_x = '0; bus.spawn_y = '0; bus.hit = 1'b0;
        push_exp(2, "reset_init", 7'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        goto(2);
        reset = 1'b0;

        // Reset mid-flight
        goto(3);
        bus.fire = 1'b1; bus.dir = 1'b0; bus.spawn_x = 7'd30; bus.spawn_y = 6'd40;
        push_exp(4, "a_launch",     7'd30, 6'd40, 1'b1, 1'b1, 1'b0);
        push_exp(6, "a_in_flight",  7'd30, 6'd40, 1'b1, 1'b1, 1'b0);
        push_exp(7, "a_reset",      7'd0,  6'd0,  1'b0, 1'b0, 1'b0);
        push_exp(9, "a_reset_hold", 7'd0,  6'd0,  1'b0, 1'b0, 1'b0);
        goto(4);
        bus.fire = 1'b0;
        goto(6);
        reset = 1'b1;
        goto(9);
        reset = 1'b0;

        // Rightward flight to the right edge; fire lands on first cycle after reset
        bus.fire = 1'b1; bus.dir = 1'b0; bus.spawn_x = 7'd10; bus.spawn_y = 6'd20;
        push_exp(10,  "b_launch",      7'd10, 6'd20, 1'b1, 1'b1, 1'b0);
        push_exp(13,  "b_before_tick", 7'd10, 6'd20, 1'b1, 1'b1, 1'b0);
        push_exp(14,  "b_tick1",       7'd12, 6'd20, 1'b1, 1'b1, 1'b0);
        push_exp(18,  "b_tick2",       7'd14, 6'd20, 1'b1, 1'b1, 1'b0);
        push_exp(166, "b_at_edge",     7'd88, 6'd20, 1'b1, 1'b1, 1'b0);
        push_exp(170, "b_retire",      7'd88, 6'd20, 1'b0, 1'b1, 1'b0);
        push_exp(181, "b_cooldown",    7'd88, 6'd20, 1'b0, 1'b1, 1'b0);
        push_exp(182, "b_idle",        7'd88, 6'd20, 1'b0, 1'b0, 1'b0);
        goto(10);
        bus.fire = 1'b0;

        // Leftward flight, no underflow at the left edge
        goto(182);
        bus.fire = 1'b1; bus.dir = 1'b1; bus.spawn_x = 7'd3; bus.spawn_y = 6'd5;
        push_exp(183, "c_launch",       7'd3, 6'd5, 1'b1, 1'b1, 1'b0);
        push_exp(187, "c_tick1",        7'd1, 6'd5, 1'b1, 1'b1, 1'b0);
        push_exp(191, "c_no_underflow", 7'd1, 6'd5, 1'b0, 1'b1, 1'b0);
        push_exp(202, "c_cooldown",     7'd1, 6'd5, 1'b0, 1'b1, 1'b0);
        push_exp(203, "c_idle",         7'd1, 6'd5, 1'b0, 1'b0, 1'b0);
        goto(183);
        bus.fire = 1'b0;

        // Clamped spawn and relaunch with fire held high
        goto(203);
        bus.fire = 1'b1; bus.dir = 1'b0; bus.spawn_x = 7'd120; bus.spawn_y = 6'd63;
        push_exp(204, "d_clamp",       7'd88, 6'd56, 1'b1, 1'b1, 1'b0);
        push_exp(208, "d_edge_retire", 7'd88, 6'd56, 1'b0, 1'b1, 1'b0);
        push_exp(219, "d_cooldown",    7'd88, 6'd56, 1'b0, 1'b1, 1'b0);
        push_exp(220, "d_busy_drop",   7'd88, 6'd56, 1'b0, 1'b0, 1'b0);
        push_exp(221, "d_relaunch",    7'd88, 6'd56, 1'b1, 1'b1, 1'b0);
        push_exp(225, "d_retire2",     7'd88, 6'd56, 1'b0, 1'b1, 1'b0);
        push_exp(237, "d_idle2",       7'd88, 6'd56, 1'b0, 1'b0, 1'b0);
        goto(221);
        bus.fire = 1'b0;

        // Hit coinciding with an edge-retirement tick; fire during cooldown/splash ignored
        goto(237);
        bus.fire = 1'b1; bus.dir = 1'b0; bus.spawn_x = 7'd88; bus.spawn_y = 6'd30;
        push_exp(238, "e_launch", 7'd88, 6'd30, 1'b1, 1'b1, 1'b0);
`ifdef WATERBALL_SPLASH_EN
        push_exp(242, "e_hit_splash",   7'd88, 6'd30, 1'b1, 1'b1, 1'b1);
        push_exp(245, "e_fire_ignored", 7'd88, 6'd30, 1'b1, 1'b1, 1'b1);
        push_exp(249, "e_splash_last",  7'd88, 6'd30, 1'b1, 1'b1, 1'b1);
        push_exp(250, "e_splash_done",  7'd88, 6'd30, 1'b0, 1'b1, 1'b0);
        push_exp(261, "e_cooldown",     7'd88, 6'd30, 1'b0, 1'b1, 1'b0);
        push_exp(262, "e_idle",         7'd88, 6'd30, 1'b0, 1'b0, 1'b0);
`else
        push_exp(242, "e_hit_retire",   7'd88, 6'd30, 1'b0, 1'b1, 1'b0);
        push_exp(245, "e_fire_ignored", 7'd88, 6'd30, 1'b0, 1'b1, 1'b0);
        push_exp(253, "e_cooldown",     7'd88, 6'd30, 1'b0, 1'b1, 1'b0);
        push_exp(254, "e_idle",         7'd88, 6'd30, 1'b0, 1'b0, 1'b0);
`endif
        goto(238);
        bus.fire = 1'b0;
        goto(241);
        bus.hit = 1'b1;
        goto(242);
        bus.hit = 1'b0;
        goto(243);
        bus.fire = 1'b1; bus.dir = 1'b1; bus.spawn_x = 7'd20; bus.spawn_y = 6'd20;
        goto(244);
        bus.fire = 1'b0;

        // Hit between ticks retires at once; fire during FLY ignored
        goto(T);
        bus.fire = 1'b1; bus.dir = 1'b1; bus.spawn_x = 7'd40; bus.spawn_y = 6'd10;
        push_exp(T + 1, "f_launch",       7'd40, 6'd10, 1'b1, 1'b1, 1'b0);
        push_exp(T + 3, "f_fire_ignored", 7'd40, 6'd10, 1'b1, 1'b1, 1'b0);
`ifdef WATERBALL_SPLASH_EN
        push_exp(T + 4,  "f_hit_no_tick", 7'd40, 6'd10, 1'b1, 1'b1, 1'b1);
        push_exp(T + 8,  "f_splash_last", 7'd40, 6'd10, 1'b1, 1'b1, 1'b1);
        push_exp(T + 9,  "f_splash_done", 7'd40, 6'd10, 1'b0, 1'b1, 1'b0);
        push_exp(T + 20, "f_cooldown",    7'd40, 6'd10, 1'b0, 1'b1, 1'b0);
        push_exp(T + 21, "f_idle",        7'd40, 6'd10, 1'b0, 1'b0, 1'b0);
`else
        push_exp(T + 4,  "f_hit_no_tick", 7'd40, 6'd10, 1'b0, 1'b1, 1'b0);
        push_exp(T + 12, "f_cooldown",    7'd40, 6'd10, 1'b0, 1'b1, 1'b0);
        push_exp(T + 13, "f_idle",        7'd40, 6'd10, 1'b0, 1'b0, 1'b0);
`endif
        goto(T + 1);
        bus.fire = 1'b0;
        goto(T + 2);
        bus.fire = 1'b1; bus.dir = 1'b0; bus.spawn_x = 7'd60; bus.spawn_y = 6'd50;
        goto(T + 3);
        bus.fire = 1'b0;
        bus.hit  = 1'b1;
        goto(T + 4);
        bus.hit  = 1'b0;

        goto(T + 25);
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            nvec++;
            nfail++;
            $display("FAIL %s: never checked, required at cycle %0d (now %0d)", m_e.name, m_e.at, cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
